// File: rtl/alu_exec_ctrl.sv
// Sequencer for an external 8-bit ALU: holds acc/dreg, issues the latched op,
// waits a per-class cycle budget, then writes the ALU result back into acc.
module alu_exec_ctrl #(
  parameter int unsigned LOGIC_WAIT  = 1,
  parameter int unsigned MULDIV_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       ready,
  input  logic [2:0] op,
  input  logic [7:0] operand,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_sub,
  output logic [2:0] alu_op_select,
  input  logic [7:0] alu_result,
  output logic [7:0] acc,
  output logic       done,
  output logic       zero,
  output logic       div_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_DIV = 3'd5;
  localparam logic [2:0] OP_LDA = 3'd6;
  localparam logic [2:0] OP_LDB = 3'd7;

  localparam logic [3:0] LOGIC_CNT  = 4'(LOGIC_WAIT);
  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] dreg_q, dreg_d;
  logic       div_err_q, div_err_d;
  logic       done_q, done_d;
  logic       accept_s;
  logic       div_zero_s;

  assign accept_s   = start && (state_q == IDLE);
  assign div_zero_s = (op == OP_DIV) && (dreg_q == 8'h00);

  // State and datapath registers; reset clears everything, aborting any op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      op_q      <= 3'd0;
      acc_q     <= 8'h00;
      dreg_q    <= 8'h00;
      div_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      dreg_q    <= dreg_d;
      div_err_q <= div_err_d;
      done_q    <= done_d;
    end
  end

  // Next-state: only ALU ops with a usable divisor leave IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && (op < OP_LDA) && !div_zero_s) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q <= 4'd1) begin
          state_d = WB;
        end else begin
          state_d = EXEC;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; loads and divide-by-zero complete without leaving IDLE
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    dreg_d    = dreg_q;
    div_err_d = div_err_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (op)
            OP_LDA: begin
              acc_d     = operand;
              div_err_d = 1'b0;
              done_d    = 1'b1;
            end
            OP_LDB: begin
              dreg_d    = operand;
              div_err_d = 1'b0;
              done_d    = 1'b1;
            end
            OP_DIV: begin
              if (div_zero_s) begin
                div_err_d = 1'b1;
                done_d    = 1'b1;
              end else begin
                op_d      = op;
                cnt_d     = MULDIV_CNT;
                div_err_d = 1'b0;
              end
            end
            default: begin
              op_d      = op;
              cnt_d     = (op >= OP_MUL) ? MULDIV_CNT : LOGIC_CNT;
              div_err_d = 1'b0;
            end
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      EXEC: cnt_d = cnt_q - 4'd1;
      WB: begin
        acc_d  = alu_result;
        done_d = 1'b1;
      end
      default: done_d = 1'b0;
    endcase
  end

  // Outputs; ready is held low while reset is asserted
  always_comb begin
    ready         = (state_q == IDLE) && !reset;
    alu_a         = acc_q;
    alu_b         = dreg_q;
    alu_sub       = (op_q == OP_SUB);
    alu_op_select = op_q;
    acc           = acc_q;
    done          = done_q;
    zero          = (acc_q == 8'h00);
    div_err       = div_err_q;
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: ALU stub, cycle-level reference model, per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_alu_exec_ctrl;

  localparam int LW = 1;
  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ready;
  logic [2:0] op;
  logic [7:0] operand;
  logic [7:0] alu_a, alu_b, alu_result, acc;
  logic       alu_sub;
  logic [2:0] alu_op_select;
  logic       done, zero, div_err;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  alu_exec_ctrl #(.LOGIC_WAIT(LW), .MULDIV_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .op(op),
    .operand(operand), .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
    .alu_op_select(alu_op_select), .alu_result(alu_result), .acc(acc),
    .done(done), .zero(zero), .div_err(div_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int unsigned r;
    case (o)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a * b;
      3'd5:    r = (b == 8'h00) ? 32'hFF : a / b;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  assign alu_result = ref_alu(alu_op_select, alu_a, alu_b);

  // Reference model: a busy countdown of W+1 cycles, result precomputed at accept
  logic [7:0] m_acc, m_dreg, m_pend;
  logic [2:0] m_op;
  logic       m_err, m_done;
  int         m_busy;
  logic       m_ready;
  assign m_ready = !reset && (m_busy == 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_acc <= 8'h00; m_dreg <= 8'h00; m_pend <= 8'h00; m_op <= 3'd0;
      m_err <= 1'b0;  m_done <= 1'b0;  m_busy <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy != 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_acc  <= m_pend;
          m_done <= 1'b1;
        end
      end else if (start) begin
        if (op == 3'd6) begin
          m_acc <= operand; m_err <= 1'b0; m_done <= 1'b1;
        end else if (op == 3'd7) begin
          m_dreg <= operand; m_err <= 1'b0; m_done <= 1'b1;
        end else if (op == 3'd5 && m_dreg == 8'h00) begin
          m_err <= 1'b1; m_done <= 1'b1;
        end else begin
          m_op   <= op;
          m_err  <= 1'b0;
          m_busy <= ((op >= 3'd4) ? MW : LW) + 1;
          m_pend <= ref_alu(op, m_acc, m_dreg);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (checking) begin
      check("ready",     8'(ready),         8'(m_ready));
      check("done",      8'(done),          8'(m_done));
      check("acc",       acc,               m_acc);
      check("alu_a",     alu_a,             m_acc);
      check("alu_b",     alu_b,             m_dreg);
      check("alu_sub",   8'(alu_sub),       8'(m_op == 3'd1));
      check("op_select", 8'(alu_op_select), 8'(m_op));
      check("zero",      8'(zero),          8'(m_acc == 8'h00));
      check("div_err",   8'(div_err),       8'(m_err));
    end
  end

  task automatic cmd(input logic [2:0] o, input logic [7:0] d);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", 8'(ready), 8'd1);
    start = 1'b1; op = o; operand = d;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lows;
    bit d_seen;
    reset = 1'b1; start = 1'b0; op = 3'd0; operand = 8'h00;
    repeat (3) @(posedge clk);
    checking = 1'b1;
    @(negedge clk);
    check("rst_ready", 8'(ready), 8'd0);
    check("rst_zero",  8'(zero),  8'd1);
    check("rst_sub",   8'(alu_sub), 8'd0);
    check("rst_opsel", 8'(alu_op_select), 8'd0);
    check("rst_acc",   acc, 8'h00);
    #1 reset = 1'b0;
    #1 check("rst_release_ready", 8'(ready), 8'd1);

    // ADD 5 + 3
    cmd(3'd6, 8'h05); cmd(3'd7, 8'h03); cmd(3'd0, 8'h00);
    @(negedge clk);
    check("add_sub_exec", 8'(alu_sub), 8'd0);
    wait_done(lat);
    check("add_latency", 8'(lat + 1), 8'd3);
    check("add_acc", acc, 8'h08);
    check("add_zero", 8'(zero), 8'd0);

    // SUB 3 - 3
    cmd(3'd6, 8'h03); cmd(3'd7, 8'h03); cmd(3'd1, 8'h00);
    @(negedge clk);
    check("sub_alu_sub", 8'(alu_sub), 8'd1);
    check("sub_opsel", 8'(alu_op_select), 8'd1);
    wait_done(lat);
    check("sub_acc", acc, 8'h00);
    check("sub_zero", 8'(zero), 8'd1);

    // MUL 0x10 * 4 with start pulses while busy
    cmd(3'd6, 8'h10); cmd(3'd7, 8'h04); cmd(3'd4, 8'h00);
    lows = 0; lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!ready) lows++;
      if (done && lat == 0) lat = i;
      #1;
      start = (i < 5); op = 3'd6; operand = 8'h99;
    end
    check("mul_ready_low", 8'(lows), 8'd5);
    check("mul_latency", 8'(lat), 8'd6);
    check("mul_acc", acc, 8'h40);

    // DIV by zero
    cmd(3'd6, 8'h2A); cmd(3'd7, 8'h00); cmd(3'd5, 8'h00);
    wait_done(lat);
    check("divz_latency", 8'(lat), 8'd1);
    check("divz_acc", acc, 8'h2A);
    check("divz_err", 8'(div_err), 8'd1);
    #1 cmd(3'd6, 8'h01);
    @(negedge clk);
    check("divz_err_clear", 8'(div_err), 8'd0);

    // DIV aborted by reset in its second EXEC cycle
    cmd(3'd6, 8'h07); cmd(3'd7, 8'h02); cmd(3'd5, 8'h00);
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_acc", acc, 8'h00);
    check("abort_done", 8'(done), 8'd0);
    check("abort_ready", 8'(ready), 8'd0);
    @(negedge clk); #1 reset = 1'b0;
    #1 check("abort_ready_after", 8'(ready), 8'd1);
    d_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d_seen = d_seen | done;
    end
    check("abort_no_done", 8'(d_seen), 8'd0);

    // 8-bit wrap, then back-to-back loads accepted while done is high
    #1 cmd(3'd6, 8'hFF); cmd(3'd7, 8'hFF); cmd(3'd0, 8'h00);
    wait_done(lat);
    check("wrap_acc", acc, 8'hFE);
    #1 start = 1'b1; op = 3'd6; operand = 8'h11;
    @(negedge clk);
    check("b2b_done1", 8'(done), 8'd1);
    #1 op = 3'd7; operand = 8'h22;
    @(negedge clk);
    check("b2b_done2", 8'(done), 8'd1);
    check("b2b_acc", acc, 8'h11);
    #1 start = 1'b0;

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #1;
      if (i % 397 == 200) begin
        reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
      end
      start   = 1'($urandom_range(0, 1));
      op      = 3'($urandom_range(0, 7));
      operand = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
    end
    @(negedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
